// File: rtl/tdm_pkg.sv
// tdm_pkg: shared FSM state type and default sizing for the TDM slot scheduler.
package tdm_pkg;
  typedef enum logic [1:0] {IDLE, HDR, SHIFT} state_t;
  localparam int N_CH_DEF = 4;
  localparam int W_DEF = 3;
endpackage

// File: rtl/tdm_slot_scheduler_if.sv
// tdm_slot_scheduler_if: requester handshake and serial output bundle.
interface tdm_slot_scheduler_if import tdm_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int W = W_DEF
) ();
  localparam int CH_W = $clog2(N_CH);
  logic en;
  logic [N_CH-1:0] req;
  logic [N_CH*W-1:0] word;
  logic [N_CH-1:0] ack;
  logic ser_out;
  logic ser_valid;
  logic [CH_W-1:0] ser_ch;
  logic frame_start;
  logic busy;
  modport master (output en, req, word, input ack, ser_out, ser_valid, ser_ch, frame_start, busy);
  modport slave (input en, req, word, output ack, ser_out, ser_valid, ser_ch, frame_start, busy);
endinterface

// File: rtl/tdm_rr_arbiter.sv
// tdm_rr_arbiter: combinational round-robin pick of the first requester at or after ptr.
module tdm_rr_arbiter import tdm_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [CH_W-1:0] gnt_idx
);
  logic [CH_W-1:0] j;
  // Scan farthest-first so the closest requester to ptr is written last and wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = '0;
    j = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      j = CH_W'((int'(ptr) + i) % N_CH);
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx = j;
      end
    end
  end
endmodule

// File: rtl/tdm_slot_scheduler.sv
// tdm_slot_scheduler: round-robin grant and LSB-first serialization of W-bit words.
// Define TDM_HDR_EN to prefix each word with the channel id (CH_W header bits).
module tdm_slot_scheduler import tdm_pkg::*; #(
  parameter int N_CH = N_CH_DEF,
  parameter int W = W_DEF
) (
  input logic clk,
  input logic rst_n,
  tdm_slot_scheduler_if.slave bus
);
  localparam int CH_W = $clog2(N_CH);
`ifdef TDM_HDR_EN
  localparam int HW = CH_W;
`else
  localparam int HW = 0;
`endif
  localparam int FL = HW + W;
  localparam int CW = $clog2(FL + 1);
  localparam state_t FIRST = HW > 0 ? HDR : SHIFT;
  state_t state;
  logic [CH_W-1:0] ptr, gnt_idx, ser_ch;
  logic [CW-1:0] cnt;
  logic [FL-1:0] shreg, fw;
  logic [N_CH-1:0] ack;
  logic gnt_valid, ser_valid, frame_start, last, arb;
  tdm_rr_arbiter #(.N_CH(N_CH)) u_arb (.req(bus.req), .ptr, .gnt_valid, .gnt_idx);
`ifdef TDM_HDR_EN
  assign fw = {bus.word[gnt_idx*W +: W], gnt_idx};
`else
  assign fw = bus.word[gnt_idx*W +: W];
`endif
  assign last = state != IDLE && cnt == CW'(FL - 1);
  assign arb = bus.en && gnt_valid && (state == IDLE || last);
  // The whole frame sits in shreg; bit 0 is the bit on the line this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      shreg <= '0;
      ack <= '0;
      ser_ch <= '0;
      ser_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ack <= arb ? N_CH'(1) << gnt_idx : '0;
      frame_start <= arb;
      if (arb) begin
        state <= FIRST;
        shreg <= fw;
        ser_ch <= gnt_idx;
        ptr <= CH_W'((int'(gnt_idx) + 1) % N_CH);
        cnt <= '0;
        ser_valid <= 1'b1;
      end else if (state != IDLE) begin
        shreg <= shreg >> 1;
        cnt <= cnt + 1'b1;
        state <= last ? IDLE : ((cnt + 1'b1) == CW'(HW) ? SHIFT : state);
        ser_valid <= !last;
      end
    end
  end
  assign bus.ack = ack;
  assign bus.ser_out = shreg[0];
  assign bus.ser_valid = ser_valid;
  assign bus.ser_ch = ser_ch;
  assign bus.frame_start = frame_start;
  assign bus.busy = ser_valid;
endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// tb_tdm_slot_scheduler: directed and randomized checks against a queue-based frame model.
module tb_tdm_slot_scheduler;
  localparam int N = 4;
  localparam int W = 3;
`ifdef TDM_HDR_EN
  localparam int HW = 2;
`else
  localparam int HW = 0;
`endif
  localparam int FL = HW + W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [N-1:0] r = '0;
  logic [N*W-1:0] wv = '0;
  int checks = 0;
  int errors = 0;
  bit q[$];
  int mptr = 0;
  logic [N-1:0] e_ack = '0;
  logic [1:0] e_ch = '0;
  logic e_fs = 1'b0;
  logic [FL-1:0] t2;
  tdm_slot_scheduler_if #(.N_CH(N), .W(W)) bus ();
  assign bus.en = en;
  assign bus.req = r;
  assign bus.word = wv;
  tdm_slot_scheduler #(.N_CH(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, got, exp, $time);
    end
  endtask

  // A word is a list of bits to emit; a new one is picked when the list runs dry.
  task automatic model_step();
    int c, win;
    win = -1;
    if (!rst_n) begin
      q.delete();
      mptr = 0;
      e_ack = '0;
      e_ch = '0;
      e_fs = 1'b0;
    end else begin
      e_ack = '0;
      e_fs = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
      if (q.size() == 0 && en)
        for (int i = 0; i < N; i++) begin
          c = (mptr + i) % N;
          if (win < 0 && r[c]) win = c;
        end
      if (win >= 0) begin
        e_ack[win] = 1'b1;
        e_ch = 2'(win);
        e_fs = 1'b1;
        for (int b = 0; b < HW; b++) q.push_back(win[b]);
        for (int b = 0; b < W; b++) q.push_back(wv[win*W+b]);
        mptr = (win + 1) % N;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("ack", 32'(bus.ack), 32'(e_ack));
    chk("ser_valid", 32'(bus.ser_valid), 32'(q.size() > 0));
    chk("ser_out", 32'(bus.ser_out), 32'(q.size() > 0 ? q[0] : 1'b0));
    chk("ser_ch", 32'(bus.ser_ch), 32'(e_ch));
    chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
    chk("busy", 32'(bus.busy), 32'(q.size() > 0));
  endtask

  initial begin
    r = 4'b1111;
    tick();
    tick();
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_valid", 32'(bus.ser_valid), 0);
    chk("rst_ch", 32'(bus.ser_ch), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    // Single request on ch2, word 110.
`ifdef TDM_HDR_EN
    t2 = 5'b11010;
`else
    t2 = 3'b110;
`endif
    rst_n = 1'b1;
    r = 4'b0100;
    wv = 12'b000_110_000_000;
    for (int b = 0; b < FL; b++) begin
      tick();
      chk("t2_bit", 32'(bus.ser_out), 32'(t2[b]));
      chk("t2_ack", 32'(bus.ack), b == 0 ? 32'b0100 : 0);
      chk("t2_fs", 32'(bus.frame_start), 32'(b == 0));
      if (b == 0) begin
        chk("t2_ch", 32'(bus.ser_ch), 2);
        r = '0;
      end
    end
    tick();
    chk("t2_end", 32'(bus.ser_valid), 0);
    // All four pending: grants rotate from channel 0 with no idle gap.
    rst_n = 1'b0;
    r = 4'b1111;
    wv = 12'b100_011_010_001;
    tick();
    rst_n = 1'b1;
    for (int f = 0; f < 5; f++)
      for (int b = 0; b < FL; b++) begin
        tick();
        chk("t3_valid", 32'(bus.ser_valid), 1);
        if (b == 0) chk("t3_order", 32'(bus.ser_ch), 32'(f % 4));
      end
    // en dropped after the first bit: word completes, nothing new granted.
    rst_n = 1'b0;
    r = 4'b0001;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_ack", 32'(bus.ack), 1);
    en = 1'b0;
    for (int b = 1; b < FL; b++) begin
      tick();
      chk("t4_valid", 32'(bus.ser_valid), 1);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("t4_idle", 32'(bus.ser_valid), 0);
      chk("t4_noack", 32'(bus.ack), 0);
    end
    // Reset mid-word drops it and restarts arbitration from channel 0.
    en = 1'b1;
    r = 4'b0010;
    tick();
    r = '0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_drop", 32'(bus.ser_valid), 0);
    rst_n = 1'b1;
    r = 4'b1010;
    tick();
    chk("t5_ptr0", 32'(bus.ack), 32'b0010);
`ifdef TDM_HDR_EN
    rst_n = 1'b0;
    r = 4'b1000;
    wv = 12'b101_000_000_000;
    tick();
    rst_n = 1'b1;
    t2 = 5'b10111;
    r = '0;
    r[3] = 1'b1;
    for (int b = 0; b < FL; b++) begin
      tick();
      r = '0;
      chk("t6_bit", 32'(bus.ser_out), 32'(t2[b]));
    end
`endif
    // Randomized requesters with occasional en drops and resets.
    rst_n = 1'b0;
    r = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++) begin
        if (bus.ack[c]) begin
          if ($urandom_range(0, 1) == 0) r[c] = 1'b0;
          wv[c*W +: W] = W'($urandom);
        end else if (!r[c] && $urandom_range(0, 3) == 0) begin
          r[c] = 1'b1;
          wv[c*W +: W] = W'($urandom);
        end
      end
      en = $urandom_range(0, 9) != 0;
      rst_n = $urandom_range(0, 299) != 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
